// File: rtl/fp_multiplier.sv
// fp_multiplier: multi-cycle IEEE-754 multiplier with a radix-2 shift-add
// significand engine followed by a single normalize/round cycle.
// Subnormal inputs are flushed to zero and results never go subnormal.
module fp_multiplier #(
  parameter int MANT_BITS = 23,
  parameter int EXP_BITS  = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          input_valid,
  input  logic [EXP_BITS+MANT_BITS:0]   in_a,
  input  logic [EXP_BITS+MANT_BITS:0]   in_b,
  output logic [EXP_BITS+MANT_BITS:0]   data_out,
  output logic                          output_valid
);

  localparam int DW = EXP_BITS + MANT_BITS + 1;  // packed word width
  localparam int W  = MANT_BITS + 1;             // significand width incl. hidden bit
  localparam int XW = EXP_BITS + 2;              // signed working exponent width
  localparam int CW = $clog2(MANT_BITS + 2);     // step counter width

  localparam logic [XW-1:0] BIAS    = XW'((1 << (EXP_BITS - 1)) - 1);
  localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_BITS) - 1);
  localparam logic [DW-1:0] QNAN    = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MANT_BITS-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    ROUND = 2'd2
  } state_t;

  state_t              state;
  logic                sign_reg;
  logic [W-1:0]        mant_a_reg;
  // Upper half accumulates partial products; lower half starts as the
  // multiplier significand and is shifted out one bit per step.
  logic [2*W-1:0]      acc_reg;
  logic [XW-1:0]       exp_reg;
  logic                nan_reg;
  logic                inf_reg;
  logic                zero_reg;
  logic [CW-1:0]       cnt_reg;

  // ---------------------------------------------------------------------
  // Operand decode (both operands share the same classification logic)
  // ---------------------------------------------------------------------
  logic [DW-1:0]       op_word [2];
  logic [EXP_BITS-1:0] op_exp  [2];
  logic [MANT_BITS-1:0] op_frac [2];
  logic [1:0]          op_nan;
  logic [1:0]          op_inf;
  logic [1:0]          op_zero;

  assign op_word[0] = in_a;
  assign op_word[1] = in_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_decode
      assign op_exp[gi]  = op_word[gi][DW-2:MANT_BITS];
      assign op_frac[gi] = op_word[gi][MANT_BITS-1:0];
      assign op_nan[gi]  = (&op_exp[gi]) & (|op_frac[gi]);
      assign op_inf[gi]  = (&op_exp[gi]) & ~(|op_frac[gi]);
      // Exponent zero covers true zero and subnormals; both flush to zero,
      // so an infinity times a subnormal is treated as inf x zero.
      assign op_zero[gi] = ~(|op_exp[gi]);
    end
  endgenerate

  logic          sign_in;
  logic          nan_in;
  logic          inf_in;
  logic          zero_in;
  logic [XW-1:0] exp_sum;

  assign sign_in = op_word[0][DW-1] ^ op_word[1][DW-1];
  assign nan_in  = (|op_nan) | ((|op_inf) & (|op_zero));
  assign inf_in  = |op_inf;
  assign zero_in = |op_zero;
  assign exp_sum = XW'(op_exp[0]) + XW'(op_exp[1]) - BIAS;

  // ---------------------------------------------------------------------
  // Shift-add step: conditionally add the multiplicand into the upper half,
  // then shift the whole accumulator (with carry) right by one.
  // ---------------------------------------------------------------------
  logic [W:0]     add_sum;
  logic [2*W-1:0] acc_next;

  assign add_sum  = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, mant_a_reg} : {(W+1){1'b0}});
  assign acc_next = {add_sum, acc_reg[W-1:1]};

  // ---------------------------------------------------------------------
  // Normalize / round (evaluated from registered state, used in ROUND)
  // ---------------------------------------------------------------------
  logic                 prod_msb;
  logic [MANT_BITS-1:0] frac_pre;
  logic                 guard_bit;
  logic                 sticky_bit;
  logic                 round_up;
  logic [MANT_BITS:0]   frac_rnd;
  logic [XW-1:0]        exp_fin;
  logic [DW-1:0]        result;

  assign prod_msb   = acc_reg[2*W-1];
  // Product lies in [1,4): pick the fraction window one bit higher when the
  // integer part is two bits wide.
  assign frac_pre   = prod_msb ? acc_reg[2*W-2:W]  : acc_reg[2*W-3:W-1];
  assign guard_bit  = prod_msb ? acc_reg[W-1]      : acc_reg[W-2];
  assign sticky_bit = prod_msb ? (|acc_reg[W-2:0]) : (|acc_reg[W-3:0]);
  assign round_up   = guard_bit & (sticky_bit | frac_pre[0]);
  assign frac_rnd   = {1'b0, frac_pre} + {{MANT_BITS{1'b0}}, round_up};
  // A carry out of the fraction leaves it all zeros and bumps the exponent.
  assign exp_fin    = exp_reg + XW'(prod_msb) + XW'(frac_rnd[MANT_BITS]);

  // Final result selection: specials first, then overflow/underflow, then normal.
  always_comb begin
    result = '0;
    if (nan_reg) begin
      result = QNAN;
    end else if (inf_reg) begin
      result = {sign_reg, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
    end else if (zero_reg) begin
      result = {sign_reg, {(DW-1){1'b0}}};
    end else if ($signed(exp_fin) >= $signed(EXP_MAX)) begin
      result = {sign_reg, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
    end else if ($signed(exp_fin) <= $signed({XW{1'b0}})) begin
      result = {sign_reg, {(DW-1){1'b0}}};
    end else begin
      result = {sign_reg, exp_fin[EXP_BITS-1:0], frac_rnd[MANT_BITS-1:0]};
    end
  end

  // Control FSM and datapath registers; output_valid is a one-cycle pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      sign_reg     <= 1'b0;
      mant_a_reg   <= '0;
      acc_reg      <= '0;
      exp_reg      <= '0;
      nan_reg      <= 1'b0;
      inf_reg      <= 1'b0;
      zero_reg     <= 1'b0;
      cnt_reg      <= '0;
      data_out     <= '0;
      output_valid <= 1'b0;
    end else begin
      output_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (input_valid) begin
            sign_reg   <= sign_in;
            mant_a_reg <= {1'b1, op_frac[0]};
            acc_reg    <= {{W{1'b0}}, 1'b1, op_frac[1]};
            exp_reg    <= exp_sum;
            nan_reg    <= nan_in;
            inf_reg    <= inf_in;
            zero_reg   <= zero_in;
            cnt_reg    <= '0;
            state      <= MUL;
          end
        end
        MUL: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(MANT_BITS)) begin
            state <= ROUND;
          end
        end
        ROUND: begin
          data_out     <= result;
          output_valid <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_multiplier.sv
// tb_fp_multiplier: directed half-precision checks of fp_multiplier covering
// arithmetic, rounding, range limits, specials, handshake and async reset.
module tb_fp_multiplier;

  logic        clk;
  logic        reset_n;
  logic        input_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [15:0] data_out;
  logic        output_valid;

  int tests_run;
  int tests_failed;

  fp_multiplier #(10, 5) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .input_valid  (input_valid),
    .in_a         (in_a),
    .in_b         (in_b),
    .data_out     (data_out),
    .output_valid (output_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation and wait (bounded) for its result; lat = edges after E0.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] res, output int lat);
    @(negedge clk);
    in_a = a;
    in_b = b;
    input_valid = 1'b1;
    @(posedge clk);
    #1;
    input_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (output_valid) begin
        lat = i;
        break;
      end
    end
    res = data_out;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    input_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (data_out !== 16'h0000 || output_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: data_out=%h output_valid=%b, required 0000/0", data_out, output_valid);
    end
    $display("[TB] reset_state data_out=%h output_valid=%b", data_out, output_valid);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] res;
    int lat;
    run_op(16'h3E00, 16'h4000, res, lat);
    tests_run++;
    if (lat !== 12) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d edges, required 12", lat);
    end
    tests_run++;
    if (res !== 16'h4200) begin
      tests_failed++;
      $display("FAIL basic_result: got %h, required 4200", res);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (output_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_pulse_width: output_valid=%b one cycle later, required 0", output_valid);
    end
    $display("[TB] basic 3e00 x 4000 -> %h latency %0d", res, lat);
  endtask

  // Table-driven vectors shared by the rounding, range and special groups.
  task automatic test_vectors(input string group, input logic [15:0] va[4],
                              input logic [15:0] vb[4], input logic [15:0] vexp[4]);
    logic [15:0] res;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], res, lat);
      tests_run++;
      if (res !== vexp[i] || lat !== 12) begin
        tests_failed++;
        $display("FAIL %s_%0d: %h x %h got %h (latency %0d), required %h (latency 12)",
                 group, i, va[i], vb[i], res, lat, vexp[i]);
      end
      $display("[TB] %s %h x %h -> %h latency %0d", group, va[i], vb[i], res, lat);
    end
  endtask

  task automatic test_rounding();
    logic [15:0] va[4]   = '{16'h3C01, 16'h3C01, 16'h3555, 16'h3C00};
    logic [15:0] vb[4]   = '{16'h3C01, 16'h3E00, 16'h4200, 16'h3C00};
    logic [15:0] vexp[4] = '{16'h3C02, 16'h3E02, 16'h3C00, 16'h3C00};
    test_vectors("rounding", va, vb, vexp);
  endtask

  task automatic test_range();
    logic [15:0] va[4]   = '{16'h7BFF, 16'h0400, 16'h8400, 16'h0001};
    logic [15:0] vb[4]   = '{16'h4000, 16'h3800, 16'h3800, 16'h7BFF};
    logic [15:0] vexp[4] = '{16'h7C00, 16'h0000, 16'h8000, 16'h0000};
    test_vectors("range", va, vb, vexp);
  endtask

  task automatic test_specials();
    logic [15:0] va[4]   = '{16'h7C00, 16'hFC00, 16'h7C01, 16'hBC00};
    logic [15:0] vb[4]   = '{16'h0000, 16'h4000, 16'h3C00, 16'h3C00};
    logic [15:0] vexp[4] = '{16'h7E00, 16'hFC00, 16'h7E00, 16'hBC00};
    test_vectors("specials", va, vb, vexp);
  endtask

  task automatic test_ignore_busy();
    int pulses;
    int first_edge;
    logic [15:0] res;
    @(negedge clk);
    in_a = 16'h3C00;
    in_b = 16'h3C00;
    input_valid = 1'b1;
    @(posedge clk);             // E0
    #1;
    input_valid = 1'b0;
    repeat (4) @(posedge clk);  // E1..E4
    #1;
    in_a = 16'h4000;
    in_b = 16'h4000;
    input_valid = 1'b1;         // sampled at E5 while busy
    pulses = 0;
    first_edge = -1;
    res = '0;
    for (int i = 5; i <= 45; i++) begin
      @(posedge clk);
      #1;
      input_valid = 1'b0;
      if (output_valid) begin
        pulses++;
        if (first_edge < 0) begin
          first_edge = i;
          res = data_out;
        end
      end
    end
    tests_run++;
    if (pulses !== 1 || first_edge !== 12) begin
      tests_failed++;
      $display("FAIL ignore_busy_pulses: %0d pulses first at E%0d, required 1 at E12", pulses, first_edge);
    end
    tests_run++;
    if (res !== 16'h3C00 || data_out !== 16'h3C00) begin
      tests_failed++;
      $display("FAIL ignore_busy_result: got %h (held %h), required 3c00", res, data_out);
    end
    $display("[TB] ignore_busy pulses=%0d at E%0d result=%h", pulses, first_edge, res);
  endtask

  task automatic test_back_to_back();
    logic [15:0] res;
    int lat;
    run_op(16'h3E00, 16'h4000, res, lat);
    // Still inside the output_valid cycle: issue the next request now.
    in_a = 16'h4000;
    in_b = 16'h4000;
    input_valid = 1'b1;
    @(posedge clk);
    #1;
    input_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (output_valid) begin
        lat = i;
        break;
      end
    end
    tests_run++;
    if (data_out !== 16'h4400 || lat !== 12) begin
      tests_failed++;
      $display("FAIL back_to_back: got %h latency %0d, required 4400 latency 12", data_out, lat);
    end
    $display("[TB] back_to_back 4000 x 4000 -> %h latency %0d", data_out, lat);
  endtask

  task automatic test_async_reset();
    logic [15:0] res;
    int lat;
    int pulses;
    @(negedge clk);
    in_a = 16'h3C00;
    in_b = 16'h4000;
    input_valid = 1'b1;
    @(posedge clk);             // E0
    #1;
    input_valid = 1'b0;
    repeat (6) @(posedge clk);  // up to E6
    #3;
    reset_n = 1'b0;             // mid-cycle, no clock edge involved
    #1;
    tests_run++;
    if (data_out !== 16'h0000 || output_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset_clear: data_out=%h output_valid=%b, required 0000/0", data_out, output_valid);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (output_valid) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin
      tests_failed++;
      $display("FAIL async_reset_no_pulse: %0d pulses after abort, required 0", pulses);
    end
    run_op(16'h4200, 16'h4200, res, lat);
    tests_run++;
    if (res !== 16'h4880 || lat !== 12) begin
      tests_failed++;
      $display("FAIL async_reset_recover: got %h latency %0d, required 4880 latency 12", res, lat);
    end
    $display("[TB] async_reset aborted_pulses=%0d recover 4200 x 4200 -> %h", pulses, res);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_rounding();
    test_range();
    test_specials();
    test_ignore_busy();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
